clk_period_meter: RTL and testbench
===================================

# clk_period_meter

Measures the waveform produced by the odd-ratio clock divider, as seen from its own source clock. Samples the divided clock, reports its period and high time in source-clock cycles, and declares lock once the period matches the expected divisor for a programmable number of consecutive cycles. Sits directly downstream of the divider and feeds status and debug logic. Also flags mismatch and loss-of-clock faults.

## Interface
- DIV_EXP, 5: expected divided-clock period in clk_in cycles; legal range 2..2^CNT_W-1
- CNT_W, 8: width of period/high counters and outputs
- LOCK_N, 4: consecutive matching periods required to assert locked; ≥1
- TIMEOUT, 255: cycles without a rising edge before a timeout fault; ≤ 2^CNT_W-1
- clk_in  input  1  single clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- en  input  1  measurement enable; low forces IDLE and clears fault
- clk_div  input  1  divided clock under test; asynchronous-looking, glitch-prone OR output
- period  output  CNT_W  last measured period in clk_in cycles
- high_cnt  output  CNT_W  clk_in posedges at which clk_div was sampled high during that period
- meas_valid  output  1  one-cycle pulse: period/high_cnt updated
- locked  output  1  period has matched DIV_EXP LOCK_N times in a row
- fault  output  1  sticky: mismatch after lock, or timeout

## Operation
- clk_div passes through a 2-flop synchronizer (s1, s2) plus a history flop s3; rise = s2 & ~s3.
- cyc_cnt: on rise loads 1; otherwise increments, saturating at 2^CNT_W-1. hi_cnt: on rise loads 1; otherwise increments when s2=1, saturating.
- On rise (except the first in ACQ/FAULT): period<=cyc_cnt, high_cnt<=hi_cnt, meas_valid<=1. This captures cycles since the previous rise.
- States:
  - IDLE: en=0. Counters held at 0, locked=0, fault=0. Transition to ACQ when en=1.
  - ACQ: the first rise only arms measurement, with no meas_valid. Each later valid measurement increments match_cnt if period==DIV_EXP, else reloads match_cnt=0. When match_cnt reaches LOCK_N, go to LOCKED.
  - LOCKED: locked=1. A measurement with period≠DIV_EXP goes to FAULT.
  - FAULT: fault=1, locked=0. The next rise is treated as the first edge, going to ACQ with match_cnt=0. fault stays set.
- Timeout: in ACQ or LOCKED (after arming), reaching cyc_cnt==TIMEOUT without a rise goes to FAULT.
- Simultaneous events:
  - rst beats en.
  - en=0 beats rise and timeout.
  - rise beats timeout in the same cycle.
- fault is cleared only by rst or en=0.
- Reset values: period=0, high_cnt=0, meas_valid=0, locked=0, fault=0, state=IDLE, all counters 0. rst mid-operation discards partial measurements.

## Timing
- A clk_div high first sampled at posedge E0 gives rise during the cycle after E1. meas_valid, period, high_cnt, locked and fault update at E2. Latency: 2 clk_in cycles from the sampling edge to registered outputs.
- locked rises in the same cycle as the LOCK_N-th matching meas_valid.
- fault rises in the same cycle as the mismatching meas_valid. On the timeout path, fault rises one cycle after cyc_cnt==TIMEOUT.
- At most one meas_valid per DIV_EXP cycles in steady state; there is no back-pressure.

## Structure
- Package clk_meter_pkg holds:
  - state enum {IDLE, ACQ, LOCKED, FAULT}
  - default CNT_W
  - saturating-increment function
- Sub-module sync_edge_det holds the 2-flop synchronizer, history flop, and rise output. It is reusable for other divided-clock taps.
- All datapath and FSM logic lives in clk_period_meter.

## Test plan
- **Steady pattern:** en=1, bench drives clk_div period 5 (3 high / 2 low).
  - First rise gives no meas_valid.
  - Each later rise gives period=5, high_cnt=3.
  - locked=1 with the 4th meas_valid.
- **Mismatch after lock:** one period of 6.
  - meas_valid with period=6, locked=0, fault=1 in the same cycle.
  - Next rise gives no meas_valid.
  - Then 4 periods of 5 give locked=1 with fault still 1.
- **Timeout:** clk_div held low 300 cycles while LOCKED, TIMEOUT=255.
  - fault=1 and locked=0 within 256 cycles of the last rise.
  - No meas_valid.
  - Recovery: first rise arms, relock after 4 matches.
- **Reset/enable:**
  - rst asserted mid-ACQ clears every output to 0 at the next posedge.
  - With fault=1, dropping en for 1 cycle clears fault, and re-acquisition starts.
- **Integration with the divider (dividor=5):**
  - Every meas_valid shows period=5 and a constant high_cnt in {2,3}.
  - locked within 6 divided periods.
  - fault never set over 1000 cycles.

Source files
------------

// File: rtl/clk_meter_pkg.sv
// Shared types and helpers for the divided-clock period meter.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } meter_state_e;

  localparam int unsigned CNT_W_DEF = 8;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus history flop; flags the rising edge of a
// slow, possibly glitchy clock-like input in the clk_in domain.
module sync_edge_det (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise
);

  logic s1, s2, s3;

  // Sync chain; s3 remembers the previous synchronized level.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign lvl  = s2;
  assign rise = s2 & ~s3;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a divided clock in clk_in cycles,
// declares lock after LOCK_N consecutive matches and flags faults.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned DIV_EXP = 5,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned LOCK_N  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             clk_div,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             locked,
  output logic             fault
);

  localparam int unsigned MC_W    = $clog2(LOCK_N + 1);
  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic lvl, rise;

  sync_edge_det u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (clk_div),
    .lvl    (lvl),
    .rise   (rise)
  );

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic [MC_W-1:0]  match_q, match_d, match_inc;
  logic             armed_q, armed_d;
  logic             mv_q, mv_d, locked_q, locked_d, fault_q, fault_d;
  logic [CNT_W-1:0] cyc_inc, hi_inc;
  logic             take_meas, is_match, is_timeout;

  assign cyc_inc    = CNT_W'(sat_inc(32'(cyc_q), CNT_MAX));
  assign hi_inc     = CNT_W'(sat_inc(32'(hi_q), CNT_MAX));
  assign match_inc  = match_q + 1'b1;
  assign is_match   = (cyc_q == CNT_W'(DIV_EXP));
  assign is_timeout = (cyc_q == CNT_W'(TIMEOUT));
  assign take_meas  = rise && ((state_q == ACQ && armed_q) || state_q == LOCKED);

  // Next-state, counter and output logic; en=0 overrides everything.
  always_comb begin
    state_d  = state_q;
    cyc_d    = rise ? CNT_W'(1) : cyc_inc;
    hi_d     = rise ? CNT_W'(1) : (lvl ? hi_inc : hi_q);
    match_d  = match_q;
    armed_d  = armed_q;
    mv_d     = 1'b0;
    period_d = period_q;
    high_d   = high_q;
    locked_d = locked_q;
    fault_d  = fault_q;

    if (take_meas) begin
      mv_d     = 1'b1;
      period_d = cyc_q;
      high_d   = hi_q;
    end

    case (state_q)
      IDLE: begin
        cyc_d    = '0;
        hi_d     = '0;
        match_d  = '0;
        armed_d  = 1'b0;
        locked_d = 1'b0;
        fault_d  = 1'b0;
        state_d  = ACQ;
      end
      ACQ: begin
        if (rise) begin
          if (!armed_q) begin
            armed_d = 1'b1;
          end else if (is_match) begin
            if (match_inc == MC_W'(LOCK_N)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              match_d  = '0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = '0;
          end
        end else if (armed_q && is_timeout) begin
          state_d  = FAULT;
          fault_d  = 1'b1;
          locked_d = 1'b0;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (!is_match) begin
            state_d  = FAULT;
            fault_d  = 1'b1;
            locked_d = 1'b0;
          end
        end else if (is_timeout) begin
          state_d  = FAULT;
          fault_d  = 1'b1;
          locked_d = 1'b0;
        end
      end
      FAULT: begin
        // This rise re-arms directly: the next rise yields a measurement.
        if (rise) begin
          state_d = ACQ;
          armed_d = 1'b1;
          match_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d  = IDLE;
      cyc_d    = '0;
      hi_d     = '0;
      match_d  = '0;
      armed_d  = 1'b0;
      mv_d     = 1'b0;
      locked_d = 1'b0;
      fault_d  = 1'b0;
      period_d = period_q;
      high_d   = high_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      hi_q     <= '0;
      match_q  <= '0;
      armed_q  <= 1'b0;
      mv_q     <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      hi_q     <= hi_d;
      match_q  <= match_d;
      armed_q  <= armed_d;
      mv_q     <= mv_d;
      period_q <= period_d;
      high_q   <= high_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
    end
  end

  assign period     = period_q;
  assign high_cnt   = high_q;
  assign meas_valid = mv_q;
  assign locked     = locked_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter with an odd-ratio divider model.
module tb_clk_period_meter;

  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             clk_drv = 1'b0;
  logic             div_mode = 1'b0;
  logic             clk_div;
  logic [CNT_W-1:0] period, high_cnt;
  logic             meas_valid, locked, fault;

  int n_chk = 0;
  int n_fail = 0;

  // Divide-by-5 with ~50% duty: posedge pulse ORed with its half-cycle delay.
  int   dcnt = 0;
  logic da = 1'b0, db = 1'b0;
  always @(posedge clk_in) begin
    dcnt <= (dcnt == 4) ? 0 : dcnt + 1;
    da   <= (dcnt < 2);
  end
  always @(negedge clk_in) db <= da;

  assign clk_div = div_mode ? (da | db) : clk_drv;

  always #5 clk_in = ~clk_in;

  clk_period_meter #(
    .DIV_EXP (5),
    .CNT_W   (CNT_W),
    .LOCK_N  (4),
    .TIMEOUT (255)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en),
    .clk_div    (clk_div),
    .period     (period),
    .high_cnt   (high_cnt),
    .meas_valid (meas_valid),
    .locked     (locked),
    .fault      (fault)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Drives one clk_div period; the measurement for the previous rise lands at j==2.
  task automatic drive_period(input int len, input int hi, input bit e_mv, input int e_per,
                              input int e_hi, input bit e_lk, input bit e_ft, input string nm);
    for (int j = 0; j < len; j++) begin
      clk_drv = (j < hi);
      tick();
      n_chk++;
      if (j == 2) begin
        if (meas_valid !== e_mv) begin
          n_fail++; $display("FAIL %s meas_valid got %b want %b", nm, meas_valid, e_mv);
        end
        if (e_mv) begin
          n_chk += 2;
          if (period !== CNT_W'(e_per)) begin
            n_fail++; $display("FAIL %s period got %0d want %0d", nm, period, e_per);
          end
          if (high_cnt !== CNT_W'(e_hi)) begin
            n_fail++; $display("FAIL %s high_cnt got %0d want %0d", nm, high_cnt, e_hi);
          end
        end
        n_chk += 2;
        if (locked !== e_lk) begin
          n_fail++; $display("FAIL %s locked got %b want %b", nm, locked, e_lk);
        end
        if (fault !== e_ft) begin
          n_fail++; $display("FAIL %s fault got %b want %b", nm, fault, e_ft);
        end
      end else if (meas_valid !== 1'b0) begin
        n_fail++; $display("FAIL %s stray meas_valid at j=%0d", nm, j);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clk_drv = 1'b0;
    repeat (3) tick();
    n_chk += 5;
    if (period !== '0)     begin n_fail++; $display("FAIL reset period got %0d want 0", period); end
    if (high_cnt !== '0)   begin n_fail++; $display("FAIL reset high_cnt got %0d want 0", high_cnt); end
    if (meas_valid !== 0)  begin n_fail++; $display("FAIL reset meas_valid got %b want 0", meas_valid); end
    if (locked !== 0)      begin n_fail++; $display("FAIL reset locked got %b want 0", locked); end
    if (fault !== 0)       begin n_fail++; $display("FAIL reset fault got %b want 0", fault); end
  endtask

  task automatic test_steady();
    rst = 1'b0; en = 1'b1; clk_drv = 1'b0;
    repeat (3) tick();
    drive_period(5, 3, 0, 0, 0, 0, 0, "steady_arm");
    drive_period(5, 3, 1, 5, 3, 0, 0, "steady_m1");
    drive_period(5, 3, 1, 5, 3, 0, 0, "steady_m2");
    drive_period(5, 3, 1, 5, 3, 0, 0, "steady_m3");
    drive_period(5, 3, 1, 5, 3, 1, 0, "steady_lock");
    drive_period(5, 3, 1, 5, 3, 1, 0, "steady_hold");
  endtask

  task automatic test_timeout();
    int ff = -1;
    int mv_seen = 0;
    bit lk_before = 1'b0;
    bit lk_at = 1'b1;
    // Last rise was at the previous period's j=0; cyc_cnt reaches 255 at its tick 256.
    clk_drv = 1'b0;
    for (int h = 0; h < 300; h++) begin
      tick();
      if (meas_valid) mv_seen++;
      if (h == 251) lk_before = locked;
      if (fault && ff < 0) begin ff = h; lk_at = locked; end
    end
    n_chk += 4;
    if (ff != 252)     begin n_fail++; $display("FAIL timeout fault_tick got %0d want 252", ff); end
    if (lk_before !== 1'b1) begin n_fail++; $display("FAIL timeout locked_before got %b want 1", lk_before); end
    if (lk_at !== 1'b0)     begin n_fail++; $display("FAIL timeout locked_at got %b want 0", lk_at); end
    if (mv_seen != 0)  begin n_fail++; $display("FAIL timeout meas_valid count got %0d want 0", mv_seen); end
    drive_period(5, 3, 0, 0, 0, 0, 1, "tmo_rearm");
    drive_period(5, 3, 1, 5, 3, 0, 1, "tmo_m1");
    drive_period(5, 3, 1, 5, 3, 0, 1, "tmo_m2");
    drive_period(5, 3, 1, 5, 3, 0, 1, "tmo_m3");
    drive_period(5, 3, 1, 5, 3, 1, 1, "tmo_relock");
  endtask

  task automatic test_enable();
    en = 1'b0; clk_drv = 1'b0;
    tick();
    n_chk += 2;
    if (fault !== 1'b0)  begin n_fail++; $display("FAIL en_drop fault got %b want 0", fault); end
    if (locked !== 1'b0) begin n_fail++; $display("FAIL en_drop locked got %b want 0", locked); end
    en = 1'b1;
    repeat (2) tick();
    drive_period(5, 3, 0, 0, 0, 0, 0, "en_arm");
    drive_period(5, 3, 1, 5, 3, 0, 0, "en_m1");
    drive_period(5, 3, 1, 5, 3, 0, 0, "en_m2");
    drive_period(5, 3, 1, 5, 3, 0, 0, "en_m3");
    drive_period(5, 3, 1, 5, 3, 1, 0, "en_lock");
  endtask

  task automatic test_mismatch();
    drive_period(6, 3, 1, 5, 3, 1, 0, "mis_long");
    drive_period(5, 3, 1, 6, 3, 0, 1, "mis_fault");
    drive_period(5, 3, 0, 0, 0, 0, 1, "mis_rearm");
    drive_period(5, 3, 1, 5, 3, 0, 1, "mis_m1");
    drive_period(5, 3, 1, 5, 3, 0, 1, "mis_m2");
    drive_period(5, 3, 1, 5, 3, 0, 1, "mis_m3");
    drive_period(5, 3, 1, 5, 3, 1, 1, "mis_relock");
  endtask

  task automatic test_rst_mid_acq();
    drive_period(7, 3, 1, 5, 3, 1, 1, "rst_pre7");
    drive_period(5, 3, 1, 7, 3, 0, 1, "rst_meas7");
    drive_period(5, 3, 0, 0, 0, 0, 1, "rst_rearm");
    clk_drv = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    n_chk += 5;
    if (period !== '0)     begin n_fail++; $display("FAIL rst_mid period got %0d want 0", period); end
    if (high_cnt !== '0)   begin n_fail++; $display("FAIL rst_mid high_cnt got %0d want 0", high_cnt); end
    if (meas_valid !== 0)  begin n_fail++; $display("FAIL rst_mid meas_valid got %b want 0", meas_valid); end
    if (locked !== 0)      begin n_fail++; $display("FAIL rst_mid locked got %b want 0", locked); end
    if (fault !== 0)       begin n_fail++; $display("FAIL rst_mid fault got %b want 0", fault); end
  endtask

  task automatic test_divider();
    int lock_t = -1;
    int n_mv = 0;
    int n_ft = 0;
    int hi0 = -1;
    clk_drv = 1'b0; div_mode = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      tick();
      if (fault) n_ft++;
      if (locked && lock_t < 0) lock_t = t;
      if (meas_valid) begin
        n_mv++;
        if (hi0 < 0) hi0 = int'(high_cnt);
        n_chk += 2;
        if (period !== CNT_W'(5)) begin
          n_fail++; $display("FAIL div period got %0d want 5 at t=%0d", period, t);
        end
        if (int'(high_cnt) != hi0) begin
          n_fail++; $display("FAIL div high_cnt got %0d want %0d at t=%0d", high_cnt, hi0, t);
        end
      end
    end
    n_chk += 4;
    if (hi0 != 2 && hi0 != 3) begin n_fail++; $display("FAIL div high_cnt_range got %0d want 2 or 3", hi0); end
    if (lock_t < 0 || lock_t > 33) begin n_fail++; $display("FAIL div lock_time got %0d want <=33", lock_t); end
    if (n_ft != 0) begin n_fail++; $display("FAIL div fault_cycles got %0d want 0", n_ft); end
    if (n_mv < 190) begin n_fail++; $display("FAIL div meas_count got %0d want >=190", n_mv); end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_timeout();
    test_enable();
    test_mismatch();
    test_rst_mid_acq();
    test_divider();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
